rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Synthesizable reset/clock-gating sequencer for one downstream clock domain, shared between N_REQ requesters.
- Performs an automatic power-on sequence after top-level reset.
- Serves domain-reset requests one at a time, round-robin. Each request gets the same ordered sequence:
  - assert domain reset and gate the clock;
  - hold for GATE_CYCLES;
  - ungate the clock;
  - hold for RELEASE_CYCLES;
  - release reset and acknowledge.

Parameters:
N_REQ, 4, number of requesters (>=2)
GATE_CYCLES, 5, cycles clk_en held low while domain reset asserted (>=1)
RELEASE_CYCLES, 5, cycles clock runs with domain reset still asserted (>=1)
CNT_W, 8, phase counter width; GATE_CYCLES and RELEASE_CYCLES must be <= 2**CNT_W

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high controller reset
req  input  N_REQ  level request per requester; held until matching ack seen
ack  output  N_REQ  one-cycle completion pulse to granted requester
grant_id  output  $clog2(N_REQ)  index of requester currently/last served
busy  output  1  high while any sequence (POR or request) in progress
domain_reset_n  output  1  active-low reset to controlled domain
clk_en  output  1  clock enable for controlled domain's gate
por_done  output  1  sticky high after power-on sequence completes

Behaviour:
- States: HOLD, RUN, DONE, IDLE. Internal por flag, phase counter cnt, round-robin pointer rr_ptr.
- Reset values (async, while reset high):
  - state=HOLD, por=1, cnt=0, rr_ptr=0;
  - domain_reset_n=0, clk_en=0, busy=1, ack=0, grant_id=0, por_done=0.
- HOLD:
  - cnt increments each cycle.
  - At the edge where cnt==GATE_CYCLES-1: clk_en<=1, cnt<=0, state<=RUN.
- RUN:
  - cnt increments each cycle.
  - At the edge where cnt==RELEASE_CYCLES-1: domain_reset_n<=1, cnt<=0, state<=DONE.
  - Same edge, if por=1: por_done<=1, por<=0, no ack.
  - Same edge, if por=0: ack[grant_id]<=1.
- DONE (exactly one cycle):
  - ack<=0, busy<=0, state<=IDLE.
  - If a request was served: rr_ptr<=grant_id+1 mod N_REQ.
  - req ignored in this state.
- IDLE: when any req bit is high at an edge:
  - winner = first set bit scanning rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ;
  - grant_id<=winner, busy<=1, domain_reset_n<=0, clk_en<=0, cnt<=0, state<=HOLD.
  - With no req: outputs stable, domain_reset_n=1, clk_en=1.
- Timing from the grant edge:
  - domain_reset_n low for GATE_CYCLES+RELEASE_CYCLES cycles;
  - clk_en low for the first GATE_CYCLES of those cycles;
  - ack high during cycle GATE_CYCLES+RELEASE_CYCLES after the grant edge, same cycle domain_reset_n returns high;
  - busy falls one cycle after ack.
- Invariants:
  - clk_en never rises while domain_reset_n is high and a sequence is starting; domain reset always precedes gating.
  - domain_reset_n never rises while clk_en=0.
- ack is one-hot or zero, never multi-bit.
- Requests arriving while busy are not lost: they are level-held and arbitrated at the next IDLE cycle. There is no coalescing; each requester is served separately.
- A requester must deassert req the cycle after it samples ack. If req is still high at the next IDLE cycle, that is a new request, arbitrated normally with rr fairness.
- Reset mid-sequence: immediate return to reset values; in-flight ack is never issued; full POR runs again. Pending requesters keep req high and are served after POR.
- Fairness: with all req held continuously, grants follow 0,1,...,N_REQ-1,0,... with no starvation.

Test Plan:
1. Deassert reset, req=0 -> domain_reset_n=0 for 10 cycles, clk_en rises after cycle 5, domain_reset_n and por_done rise at cycle 10, busy falls at cycle 11, ack never pulses.
2. After POR, req=4'b0100 for one request -> grant_id=2, domain_reset_n low 10 cycles, clk_en low first 5, ack=4'b0100 for exactly one cycle coincident with domain_reset_n rise.
3. req=4'b1111 held continuously (each drops/reasserts after own ack) -> grant order 0,1,2,3,0; every grant preceded by full 5+5 sequence and one DONE plus one IDLE cycle.
4. req[1] served while req[3] asserts mid-RUN -> req[3] granted at first IDLE after DONE, ack[3] 10 cycles after its grant, no lost request.
5. Assert reset during RUN of a request -> outputs immediately at reset values, no ack; after reset release POR completes, then the held request is served and acked.
6. Check invariants over a randomized req run -> ack always one-hot or zero; clk_en=0 implies domain_reset_n=0; busy=0 implies domain_reset_n=1 and clk_en=1.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset/clock-gating sequencer for one downstream domain: power-on sequence after
// controller reset, then round-robin service of per-requester domain-reset requests.
module rst_seq_ctrl #(
    parameter int N_REQ          = 4,
    parameter int GATE_CYCLES    = 5,
    parameter int RELEASE_CYCLES = 5,
    parameter int CNT_W          = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       domain_reset_n,
    output logic                       clk_en,
    output logic                       por_done
);

    localparam int ID_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {HOLD, RUN, DONE, IDLE} state_t;

    state_t             state, state_nxt;
    logic               por, por_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [N_REQ-1:0]   ack_nxt;
    logic [ID_W-1:0]    grant_id_nxt;
    logic               busy_nxt, domain_reset_n_nxt, clk_en_nxt, por_done_nxt;

    // Scan downward so the requester closest to ptr (in wrap order) is written last and wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] w;
        int              idx;
        w = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (r[idx]) w = ID_W'(idx);
        end
        return w;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= HOLD;
            por            <= 1'b1;
            cnt            <= '0;
            rr_ptr         <= '0;
            ack            <= '0;
            grant_id       <= '0;
            busy           <= 1'b1;
            domain_reset_n <= 1'b0;
            clk_en         <= 1'b0;
            por_done       <= 1'b0;
        end else begin
            state          <= state_nxt;
            por            <= por_nxt;
            cnt            <= cnt_nxt;
            rr_ptr         <= rr_ptr_nxt;
            ack            <= ack_nxt;
            grant_id       <= grant_id_nxt;
            busy           <= busy_nxt;
            domain_reset_n <= domain_reset_n_nxt;
            clk_en         <= clk_en_nxt;
            por_done       <= por_done_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        por_nxt            = por;
        cnt_nxt            = cnt;
        rr_ptr_nxt         = rr_ptr;
        ack_nxt            = '0;
        grant_id_nxt       = grant_id;
        busy_nxt           = busy;
        domain_reset_n_nxt = domain_reset_n;
        clk_en_nxt         = clk_en;
        por_done_nxt       = por_done;

        case (state)
            HOLD: begin
                if (cnt == GATE_LAST) begin
                    clk_en_nxt = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = RUN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (cnt == REL_LAST) begin
                    domain_reset_n_nxt = 1'b1;
                    cnt_nxt            = '0;
                    state_nxt          = DONE;
                    if (por) begin
                        por_done_nxt = 1'b1;
                        por_nxt      = 1'b0;
                    end else begin
                        ack_nxt = N_REQ'(1) << grant_id;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
                // A live ack register marks a served request; the POR pass leaves rr_ptr alone.
                if (|ack) begin
                    rr_ptr_nxt = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                end
            end
            IDLE: begin
                if (|req) begin
                    grant_id_nxt       = rr_pick(req, rr_ptr);
                    busy_nxt           = 1'b1;
                    domain_reset_n_nxt = 1'b0;
                    clk_en_nxt         = 1'b0;
                    cnt_nxt            = '0;
                    state_nxt          = HOLD;
                end
            end
            default: state_nxt = HOLD;
        endcase
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: vector table for POR and a single request, directed
// multi-cycle sequences, and a randomized run against a timeline reference model.
module tb_rst_seq_ctrl;

    localparam int N = 4;
    localparam int G = 5;
    localparam int R = 5;
    localparam int L = G + R;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] ack;
    logic [1:0]   grant_id;
    logic         busy, domain_reset_n, clk_en, por_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(.N_REQ(N), .GATE_CYCLES(G), .RELEASE_CYCLES(R), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .grant_id(grant_id),
        .busy(busy), .domain_reset_n(domain_reset_n), .clk_en(clk_en), .por_done(por_done)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] rq;
        logic [N-1:0] a;
        logic [1:0]   g;
        logic         b, dn, ce, pd;
    } vec_t;
    vec_t tbl[$];

    // Reference model: k counts edges since the current sequence started;
    // k == L+1 means idle and ready to arbitrate.
    int mk, mrr, mgid;
    bit mpor, mpd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({ack, grant_id, busy, domain_reset_n, clk_en, por_done});
    endfunction

    task automatic add(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] a,
                       input logic [1:0] g, input logic b, input logic dn, input logic ce,
                       input logic pd);
        vec_t v;
        v.rst = rst; v.rq = rq; v.a = a; v.g = g; v.b = b; v.dn = dn; v.ce = ce; v.pd = pd;
        tbl.push_back(v);
    endtask

    task automatic wait_ack(input int maxc, output int n, output logic [N-1:0] a);
        n = 0;
        do begin
            step();
            n++;
        end while (ack == '0 && n < maxc);
        a = ack;
    endtask

    task automatic do_reset(input string name);
        int n;
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 30);
        chk(name, n, L + 1);
    endtask

    task automatic model_edge(input logic rst_i, input logic [N-1:0] r);
        if (rst_i) begin
            mk = 0; mpor = 1; mrr = 0; mgid = 0; mpd = 0;
        end else if (mk == L + 1) begin
            if (r != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (r[(mrr + i) % N]) begin
                        mgid = (mrr + i) % N;
                        break;
                    end
                end
                mk = 0;
                mpor = 0;
            end
        end else begin
            mk++;
            if (mk == L && mpor) mpd = 1;
            if (mk == L + 1 && !mpor) mrr = (mgid + 1) % N;
        end
    endtask

    function automatic logic [N-1:0] model_ack();
        return (mk == L && !mpor) ? (N'(1) << mgid) : '0;
    endfunction

    function automatic logic [31:0] model_out();
        return 32'({model_ack(), 2'(mgid), mk <= L, mk >= L, mk >= G, mpd});
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           n;
        logic [N-1:0] a;
        logic [N-1:0] ea;

        // POR from reset, then one request from requester 2
        add(1, '0, '0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= L + 2; k++)
            add(0, '0, '0, 0, k <= L, k >= L, k >= G, k >= L);
        for (int k = 0; k <= L + 1; k++)
            add(0, (k <= L) ? 4'b0100 : 4'b0000, (k == L) ? 4'b0100 : 4'b0000, 2,
                k <= L, k >= L, k >= G, 1);

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            req   = tbl[i].rq;
            step();
            chk($sformatf("vec%0d", i), outs(),
                32'({tbl[i].a, tbl[i].g, tbl[i].b, tbl[i].dn, tbl[i].ce, tbl[i].pd}));
        end

        // All requesters held: round-robin 0,1,2,3,0
        do_reset("t3_por");
        req = '1;
        for (int j = 0; j < 5; j++) begin
            int x;
            x = j % N;
            wait_ack(30, n, a);
            chk($sformatf("t3_ack%0d", j), a, 32'(N'(1) << x));
            chk($sformatf("t3_gid%0d", j), grant_id, x);
            chk($sformatf("t3_gap%0d", j), n, L + 1);
            req[x] = 1'b0;
            step();
            chk($sformatf("t3_done%0d", j), busy, 0);
            req[x] = (j < 4);
        end
        req = '0;

        // Request 3 arrives mid-RUN of request 1
        do_reset("t4_por");
        req = 4'b0010;
        step();
        chk("t4_grant1", {grant_id, busy, domain_reset_n, clk_en}, {2'd1, 3'b100});
        repeat (G + 2) step();
        req[3] = 1'b1;
        wait_ack(30, n, a);
        chk("t4_ack1", a, 4'b0010);
        chk("t4_ack1_lat", n, L - (G + 2));
        req[1] = 1'b0;
        step();
        chk("t4_done", busy, 0);
        wait_ack(30, n, a);
        chk("t4_ack3", a, 4'b1000);
        chk("t4_ack3_lat", n, L + 1);
        chk("t4_gid3", grant_id, 3);
        req = '0;
        step();

        // Reset during RUN; held request served after POR
        do_reset("t5_por");
        req = 4'b0001;
        step();
        repeat (G + 2) step();
        #2 reset = 1'b1;
        #1;
        chk("t5_reset_vals", outs(), 32'({4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0}));
        step();
        reset = 1'b0;
        wait_ack(40, n, a);
        chk("t5_ack", a, 4'b0001);
        chk("t5_ack_lat", n, 2 * L + 2);
        chk("t5_por_done", por_done, 1);
        req = '0;
        step();

        // Randomized run against the reference model
        reset = 1'b1;
        req   = '0;
        @(posedge clk);
        model_edge(reset, req);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_edge(reset, req);
            #1;
            chk($sformatf("rnd%0d", c), outs(), model_out());
            chk($sformatf("inv_onehot%0d", c), 32'($onehot0(ack)), 1);
            chk($sformatf("inv_gate%0d", c), 32'(clk_en || !domain_reset_n), 1);
            chk($sformatf("inv_idle%0d", c), 32'(busy || (domain_reset_n && clk_en)), 1);
            ea = model_ack();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 499) == 0) reset = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (ea[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
